// File: rtl/regfile_wport_arbiter.sv
// Write-port arbiter for the GPR file: pipeline writeback versus one held
// long-latency result, with a forced drain when the held result starves.
module regfile_wport_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              lu_valid,
  input  logic [ADDR_W-1:0] lu_waddr,
  input  logic [DATA_W-1:0] lu_wdata,
  output logic              lu_ready,
  input  logic              flush,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              stall_req,
  output logic              pend_busy
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HELD  = 2'd1,
    S_FORCE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] baddr_q, baddr_d;
  logic [DATA_W-1:0] bdata_q, bdata_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  logic wb_active;
  logic accept;

  // Writes to r0 are architecturally dead: they neither reach the port nor block.
  assign wb_active = wb_we && (wb_waddr != '0);
  assign accept    = lu_valid && lu_ready;

  // State, buffer and starvation counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      baddr_q <= '0;
      bdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      baddr_q <= baddr_d;
      bdata_q <= bdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: capture, drain, WAW kill, starvation escalation, flush.
  always_comb begin
    state_d = state_q;
    baddr_d = baddr_q;
    bdata_d = bdata_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept && (lu_waddr != '0)) begin
          state_d = S_HELD;
          baddr_d = lu_waddr;
          bdata_d = lu_wdata;
        end
      end
      S_HELD: begin
        if (flush || !wb_active || (wb_waddr == baddr_q)) begin
          // Flushed, drained on a free port, or overwritten by the newer wb write.
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_FORCE;
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FORCE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: handshake, status decodes and the write-port mux.
  always_comb begin
    lu_ready  = 1'b0;
    stall_req = 1'b0;
    pend_busy = 1'b0;
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    if (!rst) begin
      lu_ready  = (state_q == S_IDLE) && !flush;
      stall_req = (state_q == S_FORCE);
      pend_busy = (state_q != S_IDLE);
      if ((state_q == S_FORCE) && !flush) begin
        rf_we    = 1'b1;
        rf_waddr = baddr_q;
        rf_wdata = bdata_q;
      end else if (wb_active) begin
        rf_we    = 1'b1;
        rf_waddr = wb_waddr;
        rf_wdata = wb_wdata;
      end else if ((state_q == S_HELD) && !flush) begin
        rf_we    = 1'b1;
        rf_waddr = baddr_q;
        rf_wdata = bdata_q;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Randomized bench for regfile_wport_arbiter against a pending-result model.
module tb_regfile_wport_arbiter;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ADDR_W     = 5;
  localparam int unsigned STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_waddr;
  logic [DATA_W-1:0] wb_wdata;
  logic              lu_valid;
  logic [ADDR_W-1:0] lu_waddr;
  logic [DATA_W-1:0] lu_wdata;
  logic              lu_ready;
  logic              flush;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              stall_req;
  logic              pend_busy;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: at most one pending result, and how many cycles it lost the port.
  bit                m_pend;
  bit                m_force;
  int                m_blk;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;

  regfile_wport_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .lu_valid(lu_valid), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
    .lu_ready(lu_ready), .flush(flush),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .stall_req(stall_req), .pend_busy(pend_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply inputs (called just after a falling edge) and compare against the model.
  task automatic drive(input bit r, input bit we, input logic [ADDR_W-1:0] wa,
                       input logic [DATA_W-1:0] wd, input bit lv,
                       input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ld,
                       input bit fl);
    bit                e_we, e_rdy, e_stall, e_busy, wb_act;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_data;
    rst = r; wb_we = we; wb_waddr = wa; wb_wdata = wd;
    lu_valid = lv; lu_waddr = la; lu_wdata = ld; flush = fl;
    #1;
    wb_act = we && (wa != 0);
    e_we = 0; e_addr = '0; e_data = '0;
    e_rdy = 0; e_stall = 0; e_busy = 0;
    if (!r) begin
      e_rdy   = !m_pend && !fl;
      e_stall = m_force;
      e_busy  = m_pend;
      if (m_force && !fl) begin
        e_we = 1; e_addr = m_addr; e_data = m_data;
      end else if (wb_act) begin
        e_we = 1; e_addr = wa; e_data = wd;
      end else if (m_pend && !fl) begin
        e_we = 1; e_addr = m_addr; e_data = m_data;
      end
    end
    check("rf_we", 32'(rf_we), 32'(e_we));
    check("rf_waddr", 32'(rf_waddr), 32'(e_addr));
    check("rf_wdata", rf_wdata, e_data);
    check("lu_ready", 32'(lu_ready), 32'(e_rdy));
    check("stall_req", 32'(stall_req), 32'(e_stall));
    check("pend_busy", 32'(pend_busy), 32'(e_busy));
  endtask

  // Advance one clock and update the model from the inputs held across the edge.
  task automatic tick();
    bit wb_act;
    @(posedge clk);
    wb_act = wb_we && (wb_waddr != 0);
    if (rst) begin
      m_pend = 0; m_force = 0; m_blk = 0;
    end else if (!m_pend) begin
      if (lu_valid && !flush && lu_waddr != 0) begin
        m_pend = 1; m_force = 0; m_blk = 0;
        m_addr = lu_waddr; m_data = lu_wdata;
      end
    end else if (flush || m_force || !wb_act || wb_waddr == m_addr) begin
      m_pend = 0; m_force = 0; m_blk = 0;
    end else begin
      m_blk++;
      if (m_blk == STARVE_MAX) m_force = 1;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, 0, '0, '0, 0, '0, '0, 0);
  endtask

  task automatic accept_lu(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    drive(0, 0, '0, '0, 1, a, d, 0);
    tick();
  endtask

  initial begin
    m_pend = 0; m_force = 0; m_blk = 0; m_addr = '0; m_data = '0;
    rst = 1; wb_we = 0; wb_waddr = '0; wb_wdata = '0;
    lu_valid = 0; lu_waddr = '0; lu_wdata = '0; flush = 0;
    @(negedge clk);

    // Reset holds every output low even with a live writeback.
    drive(1, 1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 0);
    check("rst_rf_we", 32'(rf_we), 32'd0);
    tick();

    // Idle writeback passes straight through.
    drive(0, 1, 5'd3, 32'h11, 0, '0, '0, 0);
    check("idle_wb_addr", 32'(rf_waddr), 32'd3);
    check("idle_wb_data", rf_wdata, 32'h11);
    check("idle_lu_ready", 32'(lu_ready), 32'd1);
    tick();

    // Free-port drain one cycle after acceptance.
    accept_lu(5'd5, 32'hAB);
    idle();
    check("drain_addr", 32'(rf_waddr), 32'd5);
    check("drain_data", rf_wdata, 32'hAB);
    check("drain_busy", 32'(pend_busy), 32'd1);
    check("drain_not_ready", 32'(lu_ready), 32'd0);
    tick();
    idle();
    check("drain_done", 32'(pend_busy), 32'd0);
    tick();

    // Starvation: four wb wins, then a one-cycle forced drain.
    accept_lu(5'd7, 32'h77);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 5'd2, 32'h20 + 32'(i), 0, '0, '0, 0);
      check("starve_wb_wins", 32'(rf_waddr), 32'd2);
      tick();
    end
    drive(0, 1, 5'd2, 32'h2F, 0, '0, '0, 0);
    check("force_stall", 32'(stall_req), 32'd1);
    check("force_addr", 32'(rf_waddr), 32'd7);
    check("force_data", rf_wdata, 32'h77);
    tick();
    drive(0, 1, 5'd2, 32'h2F, 0, '0, '0, 0);
    check("force_one_cycle", 32'(stall_req), 32'd0);
    tick();

    // WAW kill: newer wb write to the held address wins and the buffer dies.
    accept_lu(5'd9, 32'h99);
    drive(0, 1, 5'd9, 32'h55, 0, '0, '0, 0);
    check("waw_data", rf_wdata, 32'h55);
    tick();
    idle();
    check("waw_no_write", 32'(rf_we), 32'd0);
    tick();

    // r0: lu result discarded, and wb to r0 does not block the buffer.
    drive(0, 0, '0, '0, 1, 5'd0, 32'hDEAD, 0);
    tick();
    idle();
    check("r0_lu_dropped", 32'(pend_busy), 32'd0);
    tick();
    accept_lu(5'd4, 32'h44);
    drive(0, 1, 5'd0, 32'hEE, 0, '0, '0, 0);
    check("r0_wb_drain", 32'(rf_waddr), 32'd4);
    tick();

    // Flush in HELD drops the result with no write.
    accept_lu(5'd6, 32'h66);
    drive(0, 0, '0, '0, 0, '0, '0, 1);
    check("flush_no_write", 32'(rf_we), 32'd0);
    tick();
    idle();
    check("flush_busy", 32'(pend_busy), 32'd0);
    tick();

    // Reset asserted in FORCE drops stall and write immediately.
    accept_lu(5'd8, 32'h88);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 5'd3, 32'h30, 0, '0, '0, 0);
      tick();
    end
    drive(0, 1, 5'd3, 32'h31, 0, '0, '0, 0);
    check("pre_rst_stall", 32'(stall_req), 32'd1);
    drive(1, 1, 5'd3, 32'h31, 0, '0, '0, 0);
    check("rst_force_stall", 32'(stall_req), 32'd0);
    check("rst_force_we", 32'(rf_we), 32'd0);
    tick();
    idle();
    tick();

    // Randomized traffic on a small address range to provoke collisions and r0.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) < 2),
            ($urandom_range(0, 99) < 65),
            ADDR_W'($urandom_range(0, 7)),
            $urandom(),
            ($urandom_range(0, 99) < 50),
            ADDR_W'($urandom_range(0, 7)),
            $urandom(),
            ($urandom_range(0, 99) < 5));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
